// File: rtl/game_pkg.sv
// Shared constants for the game input path: key matrix geometry, mov bit
// positions, default key indices and the scan column state encoding.
package game_pkg;

  localparam int KEY_MATRIX_W = 16;

  localparam int MOV_U = 3;
  localparam int MOV_D = 2;
  localparam int MOV_L = 1;
  localparam int MOV_R = 0;

  localparam logic [3:0] IDX_UP_DEF    = 4'd1;
  localparam logic [3:0] IDX_DOWN_DEF  = 4'd9;
  localparam logic [3:0] IDX_LEFT_DEF  = 4'd4;
  localparam logic [3:0] IDX_RIGHT_DEF = 4'd6;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_e;

  // Lowest set index wins; 0 when the vector is empty.
  function automatic logic [3:0] lowest_index(input logic [KEY_MATRIX_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = KEY_MATRIX_W - 1; i >= 0; i--) begin
      if (v[i[3:0]]) idx = i[3:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin and mov-consumer bundle; master is the scanner driving columns
// and producing the debounced outputs.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] mov;
  logic       key_valid;
  logic [3:0] key_code;
  logic       frame_tick;

  modport master (
    input  row_in,
    output col_out, mov, key_valid, key_code, frame_tick
  );

  modport slave (
    output row_in,
    input  col_out, mov, key_valid, key_code, frame_tick
  );
endinterface

// File: rtl/key_debounce.sv
// Frame-level debouncer for the 16-key matrix: collects a raw frame column by
// column, then commits it once it has repeated for DEBOUNCE_FRAMES extra frames.
module key_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                    sys_clk,
  input  logic                    RST,
  input  logic                    sample_en,
  input  logic [1:0]              sample_col,
  input  logic [3:0]              sample_rows,
  input  logic                    eval,
  output logic [KEY_MATRIX_W-1:0] deb
);

  logic [KEY_MATRIX_W-1:0] raw_q, raw_d;
  logic [KEY_MATRIX_W-1:0] prev_q, prev_d;
  logic [KEY_MATRIX_W-1:0] deb_q, deb_d;
  logic [3:0]              stable_q, stable_d;
  logic                    same;

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      raw_q    <= '0;
      prev_q   <= '0;
      deb_q    <= '0;
      stable_q <= '0;
    end else begin
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      deb_q    <= deb_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    raw_d    = raw_q;
    prev_d   = prev_q;
    deb_d    = deb_q;
    stable_d = stable_q;
    same     = (raw_q == prev_q);
    if (sample_en) begin
      for (int r = 0; r < 4; r++) begin
        raw_d[{r[1:0], sample_col}] = sample_rows[r[1:0]];
      end
    end
    // Sampling and evaluation never share a cycle, so raw_q is a whole frame here.
    if (eval) begin
      prev_d = raw_q;
      if (same) begin
        stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
        if (({1'b0, stable_q} + 5'd1) == 5'(DEBOUNCE_FRAMES)) deb_d = raw_q;
      end else begin
        stable_d = '0;
      end
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates a low column drive, synchronises the row returns,
// debounces whole frames and decodes the committed matrix into mov and a key code.
module keypad_scan
  import game_pkg::*;
#(
  parameter int         SCAN_DIV        = 50000,
  parameter int         DEBOUNCE_FRAMES = 3,
  parameter logic [3:0] IDX_UP          = IDX_UP_DEF,
  parameter logic [3:0] IDX_DOWN        = IDX_DOWN_DEF,
  parameter logic [3:0] IDX_LEFT        = IDX_LEFT_DEF,
  parameter logic [3:0] IDX_RIGHT       = IDX_RIGHT_DEF
) (
  input  logic          sys_clk,
  input  logic          RST,
  keypad_scan_if.master kp
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  col_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] sync1_q, sync2_q;
  logic tick_q, tick_d;
  logic [3:0] mov_q, mov_d;
  logic valid_q, valid_d;
  logic [3:0] code_q, code_d;
  logic [KEY_MATRIX_W-1:0] deb;
  logic sample_en;
  logic up, dn, lt, rt;

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) state_q <= COL0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sample_en) begin
      case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL3;
        default: state_d = COL0;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      COL0:    kp.col_out = 4'b1110;
      COL1:    kp.col_out = 4'b1101;
      COL2:    kp.col_out = 4'b1011;
      default: kp.col_out = 4'b0111;
    endcase
  end

  assign sample_en = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d  = sample_en ? '0 : cnt_q + 1'b1;
    // Pulse lands on the cycle right after the COL3 sample: the frame's eval cycle.
    tick_d = sample_en && (state_q == COL3);
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
      tick_q  <= 1'b0;
      mov_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= kp.row_in;
      sync2_q <= sync1_q;
      tick_q  <= tick_d;
      mov_q   <= mov_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  key_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .sys_clk     (sys_clk),
    .RST         (RST),
    .sample_en   (sample_en),
    .sample_col  (state_q),
    .sample_rows (~sync2_q),
    .eval        (tick_q),
    .deb         (deb)
  );

  always_comb begin
    up = deb[IDX_UP];
    dn = deb[IDX_DOWN];
    lt = deb[IDX_LEFT];
    rt = deb[IDX_RIGHT];
    // Opposing directions cancel so the mover never sees a contradictory request.
    mov_d        = '0;
    mov_d[MOV_U] = up & ~dn;
    mov_d[MOV_D] = dn & ~up;
    mov_d[MOV_L] = lt & ~rt;
    mov_d[MOV_R] = rt & ~lt;
    valid_d      = |deb;
    code_d       = lowest_index(deb);
  end

  assign kp.mov        = mov_q;
  assign kp.key_valid  = valid_q;
  assign kp.key_code   = code_q;
  assign kp.frame_tick = tick_q;

endmodule
